pipelined_tree_multiplier: RTL and testbench

//  Parametrised, pipelined carry-save tree multiplier. Multiplies WIDTH-bit operands,

---
 rtl/pipelined_tree_multiplier.sv | 189 ++++++++++++++++++
 tb/tb_pipelined_tree_multiplier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_tree_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_tree_multiplier
//
// Three-stage pipelined carry-save tree multiplier. It multiplies two
// WIDTH-bit operands, signed or unsigned per beat, into a full 2*WIDTH-bit
// product. An opaque tag travels with each beat.
//
//   S1: capture operands, signed flag and tag
//   S2: partial products -> 3:2 CSA tree -> registered sum/carry vectors
//   S3: carry-propagate add -> out_product / out_tag
//
// All stages advance together on adv = ~out_valid | out_ready. When adv is
// low every stage holds, including bubbles.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand beat valid
//   in_ready     block can accept a beat this cycle (equals adv)
//   in_a         multiplicand, WIDTH bits
//   in_b         multiplier, WIDTH bits
//   in_signed    1 = two's-complement operands, 0 = unsigned
//   in_tag       user tag, TAG_W bits
//   out_valid    product valid
//   out_ready    consumer accepts the product this cycle
//   out_product  product modulo 2^(2*WIDTH)
//   out_tag      tag returned with the product
// ---------------------------------------------------------------------------
module pipelined_tree_multiplier #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] ZERO_P = {PW{1'b0}};
    localparam logic [PW-1:0] ONE_P  = {{(PW-1){1'b0}}, 1'b1};

    // Number of rows still to be summed at a given tree level. Each level
    // turns every full group of three rows into two and passes leftovers.
    function automatic int rows_at(input int lvl);
        int n;
        n = WIDTH;
        for (int k = 0; k < lvl; k++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

    // Number of CSA levels needed to bring w rows down to two.
    function automatic int tree_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + (n % 3);
            l++;
        end
        return l;
    endfunction

    localparam int NLEV = tree_levels(WIDTH);

    logic                 adv_s;
    logic                 s1_valid_r;
    logic [WIDTH-1:0]     s1_a_r;
    logic [WIDTH-1:0]     s1_b_r;
    logic                 s1_signed_r;
    logic [TAG_W-1:0]     s1_tag_r;
    logic                 s2_valid_r;
    logic [PW-1:0]        s2_sum_r;
    logic [PW-1:0]        s2_carry_r;
    logic [TAG_W-1:0]     s2_tag_r;
    logic [PW-1:0]        a_ext_s;
    logic [PW-1:0]        tree_s [0:NLEV][0:WIDTH-1];

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    // Sign- or zero-extend the multiplicand once; every row shifts this copy.
    assign a_ext_s = {{WIDTH{s1_signed_r & s1_a_r[WIDTH-1]}}, s1_a_r};

    // Partial product rows. In signed mode the top multiplier bit carries
    // negative weight, so its row is the negated shifted multiplicand; this
    // is also what makes min*min come out positive.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        if (i == WIDTH - 1) begin : g_top
            assign tree_s[0][i] = !s1_b_r[i]  ? ZERO_P :
                                  s1_signed_r ? (~(a_ext_s << i)) + ONE_P :
                                                (a_ext_s << i);
        end else begin : g_low
            assign tree_s[0][i] = s1_b_r[i] ? (a_ext_s << i) : ZERO_P;
        end
    end

    // Carry-save reduction tree. Row 2k/2k+1 of the next level are the sum
    // and shifted carry of rows 3k..3k+2; leftover rows pass straight down.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int N = rows_at(l);
        localparam int G = N / 3;
        localparam int R = N % 3;
        for (genvar j = 0; j < WIDTH; j++) begin : g_row
            if (j < 2 * G) begin : g_csa
                if (j % 2 == 0) begin : g_sum
                    assign tree_s[l+1][j] = tree_s[l][3*(j/2)]
                                          ^ tree_s[l][3*(j/2)+1]
                                          ^ tree_s[l][3*(j/2)+2];
                end else begin : g_carry
                    logic [PW-1:0] maj_s;
                    assign maj_s = (tree_s[l][3*(j/2)]   & tree_s[l][3*(j/2)+1])
                                 | (tree_s[l][3*(j/2)]   & tree_s[l][3*(j/2)+2])
                                 | (tree_s[l][3*(j/2)+1] & tree_s[l][3*(j/2)+2]);
                    assign tree_s[l+1][j] = {maj_s[PW-2:0], 1'b0};
                end
            end else if (j < 2 * G + R) begin : g_pass
                assign tree_s[l+1][j] = tree_s[l][3*G + (j - 2*G)];
            end else begin : g_zero
                assign tree_s[l+1][j] = ZERO_P;
            end
        end
    end

    // Stage 1: capture the operand beat; the valid bit follows in_valid
    // whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {WIDTH{1'b0}};
            s1_b_r      <= {WIDTH{1'b0}};
            s1_signed_r <= 1'b0;
            s1_tag_r    <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s1_valid_r  <= in_valid;
            s1_a_r      <= in_a;
            s1_b_r      <= in_b;
            s1_signed_r <= in_signed;
            s1_tag_r    <= in_tag;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: register the two surviving rows of the CSA tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= ZERO_P;
            s2_carry_r <= ZERO_P;
            s2_tag_r   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sum_r   <= tree_s[NLEV][0];
            s2_carry_r <= tree_s[NLEV][1];
            s2_tag_r   <= s1_tag_r;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Stage 3: final carry-propagate add; the carry out is dropped by the
    // 2*WIDTH-bit destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_product <= ZERO_P;
            out_tag     <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            out_valid   <= s2_valid_r;
            out_product <= s2_sum_r + s2_carry_r;
            out_tag     <= s2_tag_r;
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
module tb_pipelined_tree_multiplier;

    localparam int W = 32;
    localparam int T = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_signed;
    logic [T-1:0]  in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_product;
    logic [T-1:0]  out_tag;

    pipelined_tree_multiplier #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        logic [T-1:0]   t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;
    int run_len = 0;
    int max_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference product: plain 64-bit arithmetic on extended operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end else begin
            return {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    endfunction

    // Scoreboard: record accepted beats, compare every valid output in order.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            run_len = 0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", out_valid, 1'b0);
                end else begin
                    check("product", out_product, q[0].p);
                    check("tag", out_tag, q[0].t);
                    if (out_ready) void'(q.pop_front());
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (in_valid && in_ready)
                q.push_back('{p: ref_mul(in_a, in_b, in_signed), t: in_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [T-1:0] tag);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
    endtask

    // One beat with out_ready=1; checks latency and a hand-computed product.
    task automatic send_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [T-1:0] tag, input logic [2*W-1:0] exp);
        int lat;
        bit found;
        tick();
        drive(a, b, s, tag);
        tick();
        in_valid = 1'b0;
        found = 1'b0;
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                lat = k;
                break;
            end
        end
        check({name, "_seen"}, found, 1'b1);
        if (found) begin
            check({name, "_latency"}, lat, 2);
            check({name, "_lit"}, out_product, exp);
            check({name, "_tag"}, out_tag, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_product", out_product, 64'h0);
        check("rst_tag", out_tag, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // 1: 3*5 with exact latency.
        tick();
        drive(32'd3, 32'd5, 1'b0, 4'hA);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid_e0", out_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_e1", out_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_e2", out_valid, 1'b1);
        check("t1_product", out_product, 64'h0F);
        check("t1_tag", out_tag, 4'hA);
        @(negedge clk);
        check("t1_valid_e3", out_valid, 1'b0);

        // 2: all-ones operands in both modes.
        send_lit("t2_signed", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'h1, 64'h0000000000000001);
        send_lit("t2_unsigned", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h2, 64'hFFFFFFFE00000001);

        // 3: signed corners.
        send_lit("t3_minmin", 32'h80000000, 32'h80000000, 1'b1, 4'h3, 64'h4000000000000000);
        send_lit("t3_minone", 32'h80000000, 32'h00000001, 1'b1, 4'h4, 64'hFFFFFFFF80000000);
        send_lit("t3_maxmin", 32'h7FFFFFFF, 32'h80000000, 1'b1, 4'h5, 64'hC000000080000000);

        // 4: 8 back-to-back random beats.
        tick();
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(1)), 4'(i));
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check("t4_burst_run", max_run, 8);
        check("t4_drained", q.size(), 0);

        // 5: three beats in flight, then 5 stalled cycles.
        drive(32'd7, 32'd6, 1'b0, 4'h1);
        tick();
        drive($urandom, $urandom, 1'b1, 4'h2);
        tick();
        drive($urandom, $urandom, 1'b0, 4'h3);
        tick();
        out_ready = 1'b0;
        drive($urandom, $urandom, 1'b1, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_in_ready", in_ready, 1'b0);
            check("t5_hold_valid", out_valid, 1'b1);
            check("t5_hold_product", out_product, 64'd42);
            check("t5_hold_tag", out_tag, 4'h1);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("t5_drained", q.size(), 0);

        // 6: reset with two beats in flight.
        drive(32'd11, 32'd13, 1'b0, 4'h6);
        tick();
        drive(32'd17, 32'd19, 1'b0, 4'h7);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid, 1'b0);
        check("t6_product", out_product, 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6_flushed", out_valid, 1'b0);
        end
        send_lit("t6_after", 32'd9, 32'd9, 1'b0, 4'h8, 64'd81);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            tick();
            drive($urandom, $urandom, 1'($urandom_range(1)), 4'($urandom));
            in_valid = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("rand_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
